// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: instruction-cache geometry, FSM state and frame layout.
package cpu_types_pkg;

   // Default number of direct-mapped frames in the instruction cache.
   localparam int unsigned ICACHE_SETS     = 16;

   // Widest tag any legal geometry needs (SETS >= 2 leaves at most 29 tag bits);
   // narrower geometries zero-extend into this field.
   localparam int unsigned ICACHE_TAG_MAXW = 29;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } icache_state_t;

   typedef struct packed {
      logic                       valid;
      logic [ICACHE_TAG_MAXW-1:0] tag;
      logic [31:0]                data;
   } icache_frame_t;

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-frame read-only instruction cache.
// Hits return in the same cycle; misses fill one word through iREN/iaddr/iwait/iload.
// Optional hit/fill statistics counters are built when ICACHE_STATS_EN is defined.
module icache_dm
   import cpu_types_pkg::*;
#(
   parameter int unsigned SETS = ICACHE_SETS
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   localparam int unsigned IDXW = $clog2(SETS);
   localparam int unsigned TAGW = 30 - IDXW;

   icache_state_t              state;
   logic [29:0]                fill_addr;
   icache_frame_t              frames [SETS];

   logic [IDXW-1:0]            lk_idx;
   logic [TAGW-1:0]            lk_tag;
   logic [ICACHE_TAG_MAXW-1:0] lk_tag_ext;
   icache_frame_t              lk_frame;
   logic                       hit;
   logic                       miss_start;
   logic                       fill_done;

   logic [IDXW-1:0]            wr_idx;
   logic [ICACHE_TAG_MAXW-1:0] wr_tag_ext;

   // Byte offset within the word plays no part in lookup.
   logic                       unused_addr_bits;
   assign unused_addr_bits = ^imemaddr[1:0];

   assign lk_idx     = imemaddr[IDXW+1:2];
   assign lk_tag     = imemaddr[31:IDXW+2];
   assign lk_tag_ext = ICACHE_TAG_MAXW'(lk_tag);
   assign lk_frame   = frames[lk_idx];

   // Write index and tag come from the registered fill address, not the live request.
   assign wr_idx     = fill_addr[IDXW-1:0];
   assign wr_tag_ext = ICACHE_TAG_MAXW'(fill_addr[29:IDXW]);

   // Same-cycle lookup and memory-side request decode.
   always_comb begin
      hit        = 1'b0;
      miss_start = 1'b0;
      fill_done  = 1'b0;
      if (state == IDLE) begin
         hit        = imemREN && lk_frame.valid && (lk_frame.tag == lk_tag_ext);
         miss_start = imemREN && !hit;
      end else begin
         fill_done  = !iwait;
      end
      ihit     = hit;
      imemload = hit ? lk_frame.data : '0;
      iREN     = (state == FILL);
      iaddr    = {fill_addr, 2'b00};
   end

   // Miss FSM: latch the missing word address, wait on memory, return to lookup.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         fill_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (miss_start) begin
                  fill_addr <= imemaddr[31:2];
                  state     <= FILL;
               end
            end
            FILL: begin
               if (!iwait) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Frame storage: only valid bits are reset; tag/data are written on fill completion.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int unsigned i = 0; i < SETS; i++) frames[i].valid <= 1'b0;
      end else if (fill_done) begin
         frames[wr_idx] <= '{valid: 1'b1, tag: wr_tag_ext, data: iload};
      end
   end

`ifdef ICACHE_STATS_EN
   // Saturating hit and fill-start counters.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (hit && (hit_cnt != '1))         hit_cnt  <= hit_cnt + 32'd1;
         if (miss_start && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: stimulus queues expected hit data and fill requests,
// monitors compare whenever the cache presents a hit or a memory request.
module tb_icache_dm;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   icache_dm #(.SETS(16)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .ihit     (ihit),
      .imemload (imemload),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload)
`ifdef ICACHE_STATS_EN
      ,
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] addr;
      int          len;
   } fill_t;

   int          vectors     = 0;
   int          miscompares = 0;
   int          hits_seen   = 0;
   int          mem_lat     = 3;
   logic [31:0] hit_q [$];
   fill_t       fill_q [$];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h @%0t", name, act, exp, $time);
      end
   endfunction

   // Hand-assigned memory contents for the addresses the vectors touch.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h3C01_0001;
         32'h0000_0040: return 32'hDEAD_BEEF;
         32'h0000_0010: return 32'h1234_5678;
         32'h0000_0080: return 32'hA5A5_0080;
         32'h0000_0014: return 32'h0BAD_F00D;
         default:       return 32'hFFFF_0000 | a;
      endcase
   endfunction

   // Memory model: iwait high for mem_lat cycles of a request, then one cycle of valid data.
   initial begin
      int mcnt;
      mcnt = 0;
      forever begin
         @(negedge CLK);
         if (nRST && iREN) begin
            if (mcnt < mem_lat) begin
               iwait = 1'b1;
               iload = $urandom;
               mcnt++;
            end else begin
               iwait = 1'b0;
               iload = mem_word(iaddr);
               mcnt  = 0;
            end
         end else begin
            iwait = 1'b1;
            iload = $urandom;
            mcnt  = 0;
         end
      end
   end

   // Hit monitor: every ihit cycle consumes one expected instruction word.
   initial begin
      forever begin
         @(negedge CLK);
         if (nRST && ihit) begin
            hits_seen++;
            if (hit_q.size() == 0) chk("hit_unexpected", {31'd0, ihit}, 32'd0);
            else                   chk("imemload", imemload, hit_q.pop_front());
         end
      end
   end

   // Fill monitor: each request run must carry the expected address and length.
   initial begin
      fill_t cur;
      int    run_len;
      run_len  = 0;
      cur.addr = '0;
      cur.len  = 0;
      forever begin
         @(negedge CLK);
         if (!nRST) begin
            run_len = 0;
         end else if (iREN) begin
            if (run_len == 0) begin
               if (fill_q.size() == 0) begin
                  chk("fill_unexpected", {31'd0, iREN}, 32'd0);
                  cur.addr = iaddr;
                  cur.len  = 0;
               end else begin
                  cur = fill_q.pop_front();
               end
            end
            chk("iaddr", iaddr, cur.addr);
            run_len++;
         end else if (run_len > 0) begin
            chk("iren_len", 32'(run_len), 32'(cur.len));
            run_len = 0;
         end
      end
   end

   task automatic wait_hit(output int cyc, output bit ok);
      int n0;
      n0  = hits_seen;
      cyc = 0;
      ok  = 1'b0;
      while (cyc < 40 && !ok) begin
         @(posedge CLK);
         cyc++;
         if (hits_seen > n0) ok = 1'b1;
      end
      #1;
      imemREN = 1'b0;
      if (!ok) begin
         chk("hit_timeout", 32'(hits_seen - n0), 32'd1);
         if (hit_q.size() > 0) void'(hit_q.pop_front());
      end
   endtask

   // One request held until its hit; miss expects a fill and the full miss latency.
   task automatic access(input logic [31:0] a, input bit miss);
      int cyc;
      bit ok;
      imemaddr = a;
      imemREN  = 1'b1;
      hit_q.push_back(mem_word({a[31:2], 2'b00}));
      if (miss) fill_q.push_back('{addr: {a[31:2], 2'b00}, len: mem_lat + 1});
      wait_hit(cyc, ok);
      if (ok) chk(miss ? "miss_latency" : "hit_latency", 32'(cyc), miss ? 32'(mem_lat + 3) : 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cyc;
      bit  ok;
      logic [31:0] idle_addrs [4];

      nRST     = 1'b0;
      imemREN  = 1'b0;
      imemaddr = '0;
      iwait    = 1'b1;
      iload    = '0;

      // Reset state
      #2;
      chk("rst_ihit",     {31'd0, ihit}, 32'd0);
      chk("rst_imemload", imemload,      32'd0);
      chk("rst_iren",     {31'd0, iREN}, 32'd0);
      chk("rst_iaddr",    iaddr,         32'd0);
`ifdef ICACHE_STATS_EN
      chk("rst_hit_cnt",  hit_cnt,  32'd0);
      chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif
      #20 nRST = 1'b1;
      @(posedge CLK); #1;

      // Cold miss on 0x0 with three busy cycles, then warm hits incl. byte offset
      mem_lat = 3;
      access(32'h0000_0000, 1'b1);
      access(32'h0000_0002, 1'b0);
`ifdef ICACHE_STATS_EN
      chk("hit_cnt_t12",  hit_cnt,  32'd2);
      chk("miss_cnt_t12", miss_cnt, 32'd1);
`endif
      access(32'h0000_0000, 1'b0);

      // Conflict eviction on index 0
      mem_lat = 1;
      access(32'h0000_0040, 1'b1);
      access(32'h0000_0000, 1'b1);
      access(32'h0000_0040, 1'b1);
      access(32'h0000_0043, 1'b0);

      // No request: resident and non-resident addresses must not hit or fetch
      idle_addrs[0] = 32'h0000_0040;
      idle_addrs[1] = 32'h0000_0000;
      idle_addrs[2] = 32'h0000_0010;
      idle_addrs[3] = 32'hFFFF_FFFC;
      for (int i = 0; i < 10; i++) begin
         imemREN  = 1'b0;
         imemaddr = idle_addrs[i % 4];
         @(negedge CLK);
         chk("idle_ihit",     {31'd0, ihit}, 32'd0);
         chk("idle_iren",     {31'd0, iREN}, 32'd0);
         chk("idle_imemload", imemload,      32'd0);
         @(posedge CLK); #1;
      end

      // Redirect mid-fill: 0x10 still installs, then 0x80 misses
      mem_lat  = 3;
      imemaddr = 32'h0000_0010;
      imemREN  = 1'b1;
      fill_q.push_back('{addr: 32'h0000_0010, len: mem_lat + 1});
      @(posedge CLK);
      @(posedge CLK); #1;
      imemaddr = 32'h0000_0080;
      fill_q.push_back('{addr: 32'h0000_0080, len: mem_lat + 1});
      hit_q.push_back(mem_word(32'h0000_0080));
      wait_hit(cyc, ok);
      if (ok) chk("redirect_latency", 32'(cyc), 32'(2 * mem_lat + 3));
      access(32'h0000_0010, 1'b0);

      // Reset mid-fill on 0x14
      mem_lat  = 5;
      imemaddr = 32'h0000_0014;
      imemREN  = 1'b1;
      fill_q.push_back('{addr: 32'h0000_0014, len: mem_lat + 1});
      @(posedge CLK);
      @(posedge CLK); #2;
      chk("iren_pre_rst", {31'd0, iREN}, 32'd1);
      nRST = 1'b0;
      #1;
      chk("iren_async_rst", {31'd0, iREN}, 32'd0);
      chk("ihit_in_rst",    {31'd0, ihit}, 32'd0);
      chk("iaddr_in_rst",   iaddr,         32'd0);
`ifdef ICACHE_STATS_EN
      chk("hit_cnt_rst",  hit_cnt,  32'd0);
      chk("miss_cnt_rst", miss_cnt, 32'd0);
`endif
      imemREN = 1'b0;
      @(posedge CLK); #3;
      nRST = 1'b1;
      @(posedge CLK); #1;
      mem_lat = 2;
      access(32'h0000_0010, 1'b1);
      access(32'h0000_0014, 1'b1);
      access(32'h0000_0010, 1'b0);
`ifdef ICACHE_STATS_EN
      chk("hit_cnt_end",  hit_cnt,  32'd3);
      chk("miss_cnt_end", miss_cnt, 32'd2);
`endif

      repeat (3) @(posedge CLK);
      #1;
      chk("hit_q_left",  32'(hit_q.size()),  32'd0);
      chk("fill_q_left", 32'(fill_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
